// File: rtl/pio_riscv_bridge_if.sv
// pio_riscv_bridge_if: 64-bit memory/debug access bus between the bridge and the RISC-V core.
interface pio_riscv_bridge_if #(parameter int ADDR_W = 15);
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ready;
  modport master (output mem_req, mem_we, mem_sel, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_sel, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/pio_riscv_bridge.sv
// pio_riscv_bridge: turns Nios PIO commands into single 64-bit RISC-V core accesses and halt/resume requests.
module pio_riscv_bridge #(
  parameter int ADDR_W     = 15,
  parameter int TIMEOUT    = 255,
  parameter bit RESET_HALT = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] pio_addr_export,
  input  logic [5:0]        pio_control_export,
  input  logic [31:0]       pio_data_high_out_port,
  input  logic [31:0]       pio_data_low_out_port,
  output logic [31:0]       pio_data_high_in_port,
  output logic [31:0]       pio_data_low_in_port,
  output logic [1:0]        pio_riscv_flags_export,
  output logic              core_halt_req,
  input  logic              core_halted,
  pio_riscv_bridge_if.master mem
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SYNC, S_DONE} state_t;
  state_t        r_state;
  logic          r_start;
  logic          r_done;
  logic          r_halted;
  logic [63:0]   r_rdata;
  logic [CW-1:0] r_cnt;
  logic          w_start;
  logic          w_clr;
  logic [1:0]    w_op;
  logic          w_to;
  assign w_start = pio_control_export[0] & ~r_start;
  assign w_clr   = pio_control_export[5];
  assign w_op    = pio_control_export[2:1];
  assign w_to    = r_cnt == CW'(TIMEOUT - 1);
  assign pio_riscv_flags_export = {r_halted, r_done};
  assign {pio_data_high_in_port, pio_data_low_in_port} = r_rdata;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state       <= S_IDLE;
      r_start       <= 1'b0;
      r_done        <= 1'b0;
      r_halted      <= 1'b0;
      r_rdata       <= '0;
      r_cnt         <= '0;
      core_halt_req <= RESET_HALT;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_sel   <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      r_start  <= pio_control_export[0];
      r_halted <= core_halted;
      case (r_state)
        S_IDLE:
          if (w_start) begin
            r_done <= 1'b0;
            r_cnt  <= '0;
            // memory accesses are only legal while the core is parked
            if (!w_op[1] && !core_halted) begin
              r_rdata <= '1;
              r_state <= S_DONE;
            end else if (!w_op[1]) begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= w_op[0];
              mem.mem_sel   <= pio_control_export[4:3];
              mem.mem_addr  <= pio_addr_export;
              mem.mem_wdata <= {pio_data_high_out_port, pio_data_low_out_port};
              r_state       <= S_ACCESS;
            end else begin
              core_halt_req <= ~w_op[0];
              r_state       <= S_SYNC;
            end
          end else if (w_clr) r_done <= 1'b0;
        S_ACCESS:
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            r_rdata     <= mem.mem_we ? r_rdata : mem.mem_rdata;
            r_state     <= S_DONE;
          end else if (w_to) begin
            mem.mem_req <= 1'b0;
            r_rdata     <= '1;
            r_state     <= S_DONE;
          end else r_cnt <= r_cnt + CW'(1);
        S_SYNC:
          if (core_halted == core_halt_req) r_state <= S_DONE;
          else if (w_to) begin
            r_rdata <= '1;
            r_state <= S_DONE;
          end else r_cnt <= r_cnt + CW'(1);
        S_DONE: begin
          r_done  <= ~w_clr;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pio_riscv_bridge.sv
// tb_pio_riscv_bridge: directed + randomized checks of the PIO-to-RISC-V bridge against a
// transaction-level model (expected memory contents, latencies and access counts).
module tb_pio_riscv_bridge;
  localparam int AW = 15;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [5:0]    ctl = '0;
  logic [31:0]   dh = '0, dl = '0;
  logic [31:0]   rd_hi, rd_lo;
  logic [1:0]    flags;
  logic          halt_req;
  logic          halted = 1'b1;
  pio_riscv_bridge_if #(.ADDR_W(AW)) bus ();
  pio_riscv_bridge #(.ADDR_W(AW), .TIMEOUT(255), .RESET_HALT(1'b1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .pio_addr_export(addr), .pio_control_export(ctl),
    .pio_data_high_out_port(dh), .pio_data_low_out_port(dl),
    .pio_data_high_in_port(rd_hi), .pio_data_low_in_port(rd_lo),
    .pio_riscv_flags_export(flags), .core_halt_req(halt_req), .core_halted(halted), .mem(bus));
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  // memory responder state
  int          wait_cfg = 0;
  logic        ready_en = 1'b1;
  int          rcnt = 0, req_cycles = 0, n_acc = 0;
  logic        last_we;
  logic [1:0]  last_sel;
  logic [AW-1:0] last_addr;
  logic [63:0] last_wdata;
  logic [AW+1:0] rkey;
  logic [63:0] mem_m [logic [AW+1:0]];
  // reference model state
  logic [63:0] ref_mem [logic [AW+1:0]];
  logic [63:0] exp_rd = '0;
  function automatic logic [63:0] init_pat(input logic [AW+1:0] k);
    return {k, 15'h2A5, ~k, 15'h1F};
  endfunction
  always @(negedge clk) begin
    if (bus.mem_req) begin
      req_cycles++;
      rcnt++;
      bus.mem_ready = ready_en && rcnt > wait_cfg;
    end else begin
      rcnt = 0;
      bus.mem_ready = 1'b0;
    end
    bus.mem_rdata = {$urandom, $urandom};
    if (bus.mem_ready) begin
      rkey = {bus.mem_sel, bus.mem_addr};
      n_acc++;
      last_we = bus.mem_we; last_sel = bus.mem_sel; last_addr = bus.mem_addr; last_wdata = bus.mem_wdata;
      if (bus.mem_we) mem_m[rkey] = bus.mem_wdata;
      else bus.mem_rdata = mem_m.exists(rkey) ? mem_m[rkey] : init_pat(rkey);
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // drives a start edge, then scrambles the PIOs to prove the access was latched
  task automatic start_op(input logic [1:0] op, input logic [1:0] tgt, input logic [AW-1:0] a, input logic [63:0] d);
    @(negedge clk);
    ctl = {1'b0, tgt, op, 1'b1}; addr = a; dh = d[63:32]; dl = d[31:0];
    @(negedge clk);
    ctl = {1'b0, 2'($urandom), 2'($urandom), 1'b0}; addr = AW'($urandom); dh = $urandom; dl = $urandom;
  endtask
  task automatic wait_done(input int bound, output int lat);
    lat = 1;
    while (!flags[0] && lat < bound) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic mem_op(input string tag, input logic op_we, input logic [1:0] tgt, input logic [AW-1:0] a,
                        input logic [63:0] d, input int w);
    int lat, r0, a0;
    logic [AW+1:0] k;
    k = {tgt, a};
    wait_cfg = w; r0 = req_cycles; a0 = n_acc;
    start_op({1'b0, op_we}, tgt, a, d);
    wait_done(40, lat);
    if (op_we) ref_mem[k] = d;
    else exp_rd = ref_mem.exists(k) ? ref_mem[k] : init_pat(k);
    check({tag, ".done"}, 64'(flags[0]), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(3 + w));
    check({tag, ".req_cycles"}, 64'(req_cycles - r0), 64'(w + 1));
    check({tag, ".accesses"}, 64'(n_acc - a0), 64'd1);
    check({tag, ".we_sel_addr"}, {45'd0, last_we, last_sel, last_addr}, {45'd0, op_we, tgt, a});
    if (op_we) check({tag, ".wdata"}, last_wdata, d);
    check({tag, ".rd_hi"}, 64'(rd_hi), 64'(exp_rd[63:32]));
    check({tag, ".rd_lo"}, 64'(rd_lo), 64'(exp_rd[31:0]));
  endtask
  initial begin
    int lat, r0, a0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.mem_req", 64'(bus.mem_req), 64'd0);
    check("reset.halt_req", 64'(halt_req), 64'd1);
    check("reset.flags", 64'(flags), 64'd0);
    check("reset.rdata", {rd_hi, rd_lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_op("wr_imem", 1'b1, 2'b00, AW'('h10), 64'h0000_0013_DEAD_BEEF, 0);
    mem_op("rd_imem", 1'b0, 2'b00, AW'('h10), 64'd0, 4);
    for (int i = 0; i < 16; i++)
      mem_op("rand", 1'($urandom), 2'($urandom), AW'($urandom_range(0, 7)), {$urandom, $urandom}, $urandom_range(0, 5));
    // resume: core drops its halted ack five cycles after the request
    start_op(2'b11, 2'b00, '0, '0);
    check("resume.halt_req", 64'(halt_req), 64'd0);
    repeat (4) @(negedge clk);
    check("resume.wait_ack", 64'(flags[0]), 64'd0);
    halted = 1'b0;
    wait_done(20, lat);
    check("resume.done", 64'(flags[0]), 64'd1);
    check("resume.flag_halted", 64'(flags[1]), 64'd0);
    // read while the core runs: no bus traffic, data forced to all-ones
    r0 = req_cycles; a0 = n_acc;
    start_op(2'b00, 2'b01, AW'('h10), '0);
    wait_done(10, lat);
    exp_rd = '1;
    check("running.done", 64'(flags[0]), 64'd1);
    check("running.latency", 64'(lat), 64'd2);
    check("running.no_req", 64'(req_cycles - r0), 64'd0);
    check("running.rdata", {rd_hi, rd_lo}, exp_rd);
    // halt: ack rises seven cycles after the start edge
    start_op(2'b10, 2'b00, '0, '0);
    check("halt.halt_req", 64'(halt_req), 64'd1);
    repeat (6) @(negedge clk);
    check("halt.wait_ack", 64'(flags[0]), 64'd0);
    halted = 1'b1;
    wait_done(20, lat);
    check("halt.done", 64'(flags[0]), 64'd1);
    check("halt.flag_halted", 64'(flags[1]), 64'd1);
    check("halt.rdata_kept", {rd_hi, rd_lo}, exp_rd);
    @(negedge clk);
    ctl[5] = 1'b1;
    @(negedge clk);
    check("clear.done", 64'(flags[0]), 64'd0);
    ctl[5] = 1'b0;
    mem_op("rd_again", 1'b0, 2'b00, AW'('h10), 64'd0, 0);
    // mem_ready stuck low: timeout, with a stray start in the middle
    ready_en = 1'b0;
    r0 = req_cycles; a0 = n_acc;
    start_op(2'b00, 2'b01, AW'('h3), '0);
    repeat (50) @(negedge clk);
    ctl[0] = 1'b1;
    @(negedge clk);
    ctl[0] = 1'b0;
    wait_done(400, lat);
    check("timeout.done", 64'(flags[0]), 64'd1);
    check("timeout.req_cycles", 64'(req_cycles - r0), 64'd255);
    check("timeout.rdata", {rd_hi, rd_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (5) @(negedge clk);
    check("timeout.no_extra_req", 64'(req_cycles - r0), 64'd255);
    check("timeout.accesses", 64'(n_acc - a0), 64'd0);
    // asynchronous reset in the middle of an access
    a0 = n_acc;
    start_op(2'b01, 2'b01, AW'('h5), 64'h1234);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.mem_req", 64'(bus.mem_req), 64'd0);
    check("midreset.halt_req", 64'(halt_req), 64'd1);
    check("midreset.flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_en = 1'b1;
    check("midreset.no_access", 64'(n_acc - a0), 64'd0);
    @(negedge clk);
    exp_rd = '0;
    mem_op("after_reset", 1'b1, 2'b01, AW'('h5), {$urandom, $urandom}, 1);
    check("after_reset.flag_halted", 64'(flags[1]), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pio_riscv_bridge.md
Name: pio_riscv_bridge

Overview:
- Sits directly downstream of the Nios II coprocessor system. It consumes that system's PIO outputs: address, control, and high/low write data.
- It turns them into single 64-bit accesses on the RISC-V core's memory/debug port, plus halt and resume requests to the core.
- It drives back the PIO inputs: 64-bit read data and the 2-bit status flags.
- All logic runs in one clock domain, the Nios clock.

Parameters:
- ADDR_W, 15, access address width; matches the PIO address width.
- TIMEOUT, 255, maximum cycles to wait for mem_ready or a core halt/resume acknowledge.
- RESET_HALT, 1, reset value of core_halt_req; the core is held halted at reset so software can load it.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  reset, asynchronous, active-low
- pio_addr_export  in  ADDR_W  word address of the access
- pio_control_export  in  6  [0] start (rising edge), [2:1] op, [4:3] target, [5] clear done (level)
- pio_data_high_out_port  in  32  write data [63:32]
- pio_data_low_out_port  in  32  write data [31:0]
- pio_data_high_in_port  out  32  read data [63:32]
- pio_data_low_in_port  out  32  read data [31:0]
- pio_riscv_flags_export  out  2  [0] done, [1] core halted
- core_halt_req  out  1  halt request to the RISC-V core
- core_halted  in  1  core acknowledge: the core is halted
- mem_req  out  1  access request
- mem_we  out  1  1 = write, 0 = read
- mem_sel  out  2  target: 00 imem, 01 dmem, 10 regfile, 11 csr
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  64  write data
- mem_rdata  in  64  read data, valid in the cycle mem_ready = 1
- mem_ready  in  1  access complete

Behaviour:
- Reset values (async, active-low):
  - All outputs are 0, except core_halt_req = RESET_HALT.
  - FSM is in IDLE; the timeout counter is 0.
  - The control[0] edge register is loaded with 0, so a start level already high at reset release counts as an edge.
- Start detection: start = control[0] AND NOT control[0] registered.
  - A start is accepted only in IDLE; outside IDLE it is dropped with no side effects.
- Latching: on an accepted start, addr, op, target and {high, low} write data are latched. Later changes to the PIOs do not affect the access in flight.
- An accepted start clears done in that same cycle.
- Op encoding: 00 read, 01 write, 10 halt, 11 resume.
- FSM states: IDLE, ACCESS, SYNC, DONE.
- IDLE:
  - Start with a read/write op while core_halted = 0: go to DONE; read data is forced to all-ones; no memory access is made.
  - Start with a read/write op while core_halted = 1: go to ACCESS; mem_req, mem_we, mem_sel, mem_addr and mem_wdata are registered and valid from the next cycle.
  - Start with halt: set core_halt_req = 1, go to SYNC.
  - Start with resume: set core_halt_req = 0, go to SYNC.
- ACCESS:
  - mem_req and the other mem_* outputs are held stable until mem_ready = 1 is sampled.
  - On that edge, a read captures mem_rdata into the PIO read-data outputs; mem_req drops the next cycle; go to DONE.
  - A write leaves the read-data outputs unchanged.
  - Minimum latency from accepted start to done = 1 is 3 cycles, when mem_ready is high in the first ACCESS cycle.
- SYNC: wait until core_halted equals the requested state (1 for halt, 0 for resume), then go to DONE. If the condition already holds on entry, exit after one cycle.
- Timeout:
  - The counter resets on entry to ACCESS or SYNC and increments every cycle in those states.
  - When it reaches TIMEOUT: drop mem_req, force read data to all-ones, go to DONE.
  - On a SYNC timeout, core_halt_req keeps its requested value.
- DONE: flags[0] = 1, sticky. Return to IDLE in the next cycle.
- Clear: control[5] = 1 clears flags[0] only in IDLE or DONE; it is ignored while in ACCESS or SYNC.
- Clear and start in the same cycle in IDLE: start wins and done = 0.
- flags[1] = core_halted, registered with one cycle of delay.
- Read data holds its last value until the next completed read or forced all-ones.
- Reset mid-access: mem_req drops immediately (async); no access completes.

Test Plan:
- Halted core, write op to imem at addr 0x0010 with data 0x0000_0013_DEAD_BEEF, mem_ready tied high -> one mem_req pulse with mem_we = 1, mem_sel = 00, mem_addr = 0x0010, mem_wdata = 0x00000013DEADBEEF; flags[0] = 1 three cycles after the control[0] edge.
- Read the same location back, with the memory model returning data after 4 wait cycles -> mem_req held 5 cycles; data_high_in = 0x00000013, data_low_in = 0xDEADBEEF; done = 1.
- Core running (core_halted = 0), read op -> no mem_req; done = 1; both read-data halves = 0xFFFFFFFF.
- Halt op with core_halted rising 7 cycles later -> core_halt_req = 1 immediately; done = 1 after the ack; flags[1] = 1. Then resume -> core_halt_req = 0; done follows core_halted falling.
- mem_ready stuck low, TIMEOUT = 255 -> mem_req deasserts after 255 ACCESS cycles; read data = all-ones; done = 1. A second start during the wait is ignored (no extra access).
- Assert reset_reset_n = 0 mid-ACCESS -> mem_req = 0 asynchronously; core_halt_req = RESET_HALT; flags = 0. After reset release, a fresh start completes normally.
